// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, special register IDs and basic types.
package y86_pkg;

  typedef logic [3:0]  reg_id_t;
  typedef logic [63:0] word_t;

  typedef enum logic [3:0] {
    HALT  = 4'h0,
    NOP   = 4'h1,
    RRMOV = 4'h2,
    IRMOV = 4'h3,
    RMMOV = 4'h4,
    MRMOV = 4'h5,
    OPQ   = 4'h6,
    JXX   = 4'h7,
    CALL  = 4'h8,
    RET   = 4'h9,
    PUSH  = 4'hA,
    POP   = 4'hB
  } icode_e;

  localparam reg_id_t RSP   = 4'h4;
  localparam reg_id_t RNONE = 4'hF;

endpackage

// File: rtl/regfile_2r2w.sv
// Register file with two async read ports and two sync write ports.
// Port M overrides port E on the same register; ID 0xF reads 0 and never writes.
module regfile_2r2w
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         ra_id_i,
  input  logic [3:0]                         rb_id_i,
  output logic [DATA_W-1:0]                  ra_o,
  output logic [DATA_W-1:0]                  rb_o,
  input  logic [3:0]                         e_id_i,
  input  logic [DATA_W-1:0]                  e_data_i,
  input  logic [3:0]                         m_id_i,
  input  logic [DATA_W-1:0]                  m_data_i,
  output logic [NUM_REGS-1:0][DATA_W-1:0]    regs_o
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;

  // Index loops keep the out-of-range ID 0xF from ever matching an entry.
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (e_id_i == i[3:0]) regs_d[i] = e_data_i;
      if (m_id_i == i[3:0]) regs_d[i] = m_data_i;
    end
  end

  always_comb begin
    ra_o = '0;
    rb_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ra_id_i == i[3:0]) ra_o = regs_q[i];
      if (rb_id_i == i[3:0]) rb_o = regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) regs_q <= '0;
    else     regs_q <= regs_d;
  end

  assign regs_o = regs_q;

endmodule

// File: rtl/decode_writeback.sv
// Y86-64 decode and write-back stage: operand read selection, destination
// selection and the architectural register file, with all registers exported.
module decode_writeback
  import y86_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        iCode,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic              cnd,
  input  logic [DATA_W-1:0] valE,
  input  logic [DATA_W-1:0] valM,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  output logic [DATA_W-1:0] memreg0,
  output logic [DATA_W-1:0] memreg1,
  output logic [DATA_W-1:0] memreg2,
  output logic [DATA_W-1:0] memreg3,
  output logic [DATA_W-1:0] memreg4,
  output logic [DATA_W-1:0] memreg5,
  output logic [DATA_W-1:0] memreg6,
  output logic [DATA_W-1:0] memreg7,
  output logic [DATA_W-1:0] memreg8,
  output logic [DATA_W-1:0] memreg9,
  output logic [DATA_W-1:0] memreg10,
  output logic [DATA_W-1:0] memreg11,
  output logic [DATA_W-1:0] memreg12,
  output logic [DATA_W-1:0] memreg13,
  output logic [DATA_W-1:0] memreg14
);

  reg_id_t src_a, src_b, dst_e, dst_m;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;

  // Unused read/write slots are parked on RNONE, which reads 0 and never writes.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode_e'(iCode))
      RRMOV, RMMOV, OPQ, PUSH: src_a = rA;
      RET, POP:                src_a = RSP;
      default:                 src_a = RNONE;
    endcase
    case (icode_e'(iCode))
      RMMOV, MRMOV, OPQ:       src_b = rB;
      CALL, RET, PUSH, POP:    src_b = RSP;
      default:                 src_b = RNONE;
    endcase
    case (icode_e'(iCode))
      RRMOV:                   dst_e = cnd ? rB : RNONE;
      IRMOV, OPQ:              dst_e = rB;
      CALL, RET, PUSH, POP:    dst_e = RSP;
      default:                 dst_e = RNONE;
    endcase
    case (icode_e'(iCode))
      MRMOV, POP:              dst_m = rA;
      default:                 dst_m = RNONE;
    endcase
  end

  regfile_2r2w #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk      (clk),
    .rst      (rst),
    .ra_id_i  (src_a),
    .rb_id_i  (src_b),
    .ra_o     (valA),
    .rb_o     (valB),
    .e_id_i   (dst_e),
    .e_data_i (valE),
    .m_id_i   (dst_m),
    .m_data_i (valM),
    .regs_o   (regs)
  );

  assign memreg0  = regs[0];
  assign memreg1  = regs[1];
  assign memreg2  = regs[2];
  assign memreg3  = regs[3];
  assign memreg4  = regs[4];
  assign memreg5  = regs[5];
  assign memreg6  = regs[6];
  assign memreg7  = regs[7];
  assign memreg8  = regs[8];
  assign memreg9  = regs[9];
  assign memreg10 = regs[10];
  assign memreg11 = regs[11];
  assign memreg12 = regs[12];
  assign memreg13 = regs[13];
  assign memreg14 = regs[14];

endmodule

// File: tb/tb_decode_writeback.sv
// Directed bench for decode_writeback: hand-tracked register image and operand checks.
module tb_decode_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  iCode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM, valA, valB;
  logic [63:0] mr  [15];
  logic [63:0] exp_r [15];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [63:0] m0, m1, m2, m3, m4, m5, m6, m7, m8, m9, m10, m11, m12, m13, m14;

  decode_writeback dut (
    .clk(clk), .rst(rst), .iCode(iCode), .rA(rA), .rB(rB), .cnd(cnd),
    .valE(valE), .valM(valM), .valA(valA), .valB(valB),
    .memreg0(m0), .memreg1(m1), .memreg2(m2), .memreg3(m3), .memreg4(m4),
    .memreg5(m5), .memreg6(m6), .memreg7(m7), .memreg8(m8), .memreg9(m9),
    .memreg10(m10), .memreg11(m11), .memreg12(m12), .memreg13(m13), .memreg14(m14)
  );

  assign mr[0] = m0;   assign mr[1] = m1;   assign mr[2] = m2;   assign mr[3] = m3;
  assign mr[4] = m4;   assign mr[5] = m5;   assign mr[6] = m6;   assign mr[7] = m7;
  assign mr[8] = m8;   assign mr[9] = m9;   assign mr[10] = m10; assign mr[11] = m11;
  assign mr[12] = m12; assign mr[13] = m13; assign mr[14] = m14;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < 15; i++)
      chk($sformatf("%s R%0d", tag, i), mr[i], exp_r[i]);
  endtask

  // Apply inputs mid-cycle, let decode settle.
  task automatic drive(input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    iCode = ic; rA = a; rB = b; cnd = c; valE = e; valM = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 15; i++) exp_r[i] = '0;

    // Reset wins over a simultaneous irmovq.
    rst = 1'b1;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'hDEAD, 64'h0);
    tick();
    chk_regs("reset");
    rst = 1'b0;
    drive(4'h6, 4'h2, 4'hB, 1'b0, 64'h0, 64'h0);
    chk("reset valA", valA, 64'h0);
    chk("reset valB", valB, 64'h0);

    // OPq writing zero for several edges.
    tick(); tick(); tick();
    chk_regs("opq zero");

    // irmovq R11=7, then OPq reads it.
    drive(4'h3, 4'hF, 4'hB, 1'b0, 64'h7, 64'h0);
    tick(); exp_r[11] = 64'h7;
    chk_regs("irmov r11");
    drive(4'h3, 4'hF, 4'h2, 1'b0, 64'h22, 64'h0);
    tick(); exp_r[2] = 64'h22;
    drive(4'h6, 4'h2, 4'hB, 1'b0, 64'h29, 64'h0);
    chk("opq valA", valA, 64'h22);
    chk("opq valB", valB, 64'h7);
    tick(); exp_r[11] = 64'h29;
    chk_regs("opq r11");

    // mrmovq: M to rA, rB read only.
    drive(4'h5, 4'h3, 4'hB, 1'b0, 64'h99, 64'h55);
    chk("mrmov valA", valA, 64'h0);
    chk("mrmov valB", valB, 64'h29);
    tick(); exp_r[3] = 64'h55;
    chk_regs("mrmov");

    // cmov gating.
    drive(4'h3, 4'hF, 4'h1, 1'b0, 64'h11, 64'h0);
    tick(); exp_r[1] = 64'h11;
    drive(4'h2, 4'h1, 4'h6, 1'b0, 64'h9, 64'h0);
    chk("cmov valA", valA, 64'h11);
    chk("cmov valB", valB, 64'h0);
    tick();
    chk_regs("cmov cnd0");
    drive(4'h2, 4'h1, 4'h6, 1'b1, 64'h9, 64'h0);
    tick(); exp_r[6] = 64'h9;
    chk_regs("cmov cnd1");

    // Stack operations.
    drive(4'h3, 4'hF, 4'h4, 1'b0, 64'h100, 64'h0);
    tick(); exp_r[4] = 64'h100;
    drive(4'hA, 4'h1, 4'hF, 1'b0, 64'hF8, 64'h0);
    chk("push valA", valA, 64'h11);
    chk("push valB", valB, 64'h100);
    chk("push pre-edge r4", mr[4], 64'h100);
    tick(); exp_r[4] = 64'hF8;
    chk_regs("push");

    drive(4'h4, 4'h1, 4'h3, 1'b0, 64'hAAAA, 64'hBBBB);
    chk("rmmov valA", valA, 64'h11);
    chk("rmmov valB", valB, 64'h55);
    tick();
    chk_regs("rmmov");

    drive(4'h8, 4'h1, 4'h2, 1'b0, 64'hF0, 64'h0);
    chk("call valA", valA, 64'h0);
    chk("call valB", valB, 64'hF8);
    tick(); exp_r[4] = 64'hF0;
    chk_regs("call");

    drive(4'h9, 4'h1, 4'h2, 1'b0, 64'hF8, 64'h1234);
    chk("ret valA", valA, 64'hF0);
    chk("ret valB", valB, 64'hF0);
    tick(); exp_r[4] = 64'hF8;
    chk_regs("ret");

    drive(4'hB, 4'h4, 4'hF, 1'b0, 64'h100, 64'h42);
    chk("pop rsp valA", valA, 64'hF8);
    chk("pop rsp valB", valB, 64'hF8);
    tick(); exp_r[4] = 64'h42;
    chk_regs("pop rsp");

    drive(4'hB, 4'h7, 4'hF, 1'b0, 64'h50, 64'h77);
    chk("pop r7 valA", valA, 64'h42);
    tick(); exp_r[4] = 64'h50; exp_r[7] = 64'h77;
    chk_regs("pop r7");

    // Edge register IDs 0 and 14.
    drive(4'h3, 4'hF, 4'h0, 1'b0, 64'h1, 64'h0);
    tick(); exp_r[0] = 64'h1;
    drive(4'h3, 4'hF, 4'hE, 1'b0, 64'hE, 64'h0);
    tick(); exp_r[14] = 64'hE;
    chk_regs("r0 r14");
    drive(4'h6, 4'h0, 4'hE, 1'b0, 64'hF, 64'h0);
    chk("opq r0 valA", valA, 64'h1);
    chk("opq r14 valB", valB, 64'hE);
    tick(); exp_r[14] = 64'hF;

    // No-write codes and RNONE targets.
    drive(4'h0, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD);
    tick();
    drive(4'h1, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD);
    tick();
    drive(4'h7, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD);
    chk("jxx valA", valA, 64'h0);
    chk("jxx valB", valB, 64'h0);
    tick();
    drive(4'hC, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD);
    chk("undef valA", valA, 64'h0);
    tick();
    drive(4'hF, 4'h2, 4'h3, 1'b1, 64'hBAD, 64'hBAD);
    tick();
    drive(4'h3, 4'hF, 4'hF, 1'b0, 64'hBAD, 64'hBAD);
    tick();
    drive(4'h6, 4'hF, 4'hF, 1'b0, 64'hBAD, 64'hBAD);
    chk("rnone valA", valA, 64'h0);
    chk("rnone valB", valB, 64'h0);
    tick();
    chk_regs("no write");

    // Reset again with an irmovq presented.
    rst = 1'b1;
    drive(4'h3, 4'hF, 4'h5, 1'b0, 64'h1234, 64'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) exp_r[i] = '0;
    chk_regs("reset2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
